vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 26 ++
 rtl/vram_host_fifo.sv | 50 +++++
 rtl/vram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and parameter defaults for the character VRAM arbiter.
package vram_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        SCAN,
        HOST,
        CLR
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    localparam int DEPTH_DEF = 1200;
    localparam int DATA_W_DEF = 8;
    localparam int STARVE_LIMIT_DEF = 64;
    localparam logic [7:0] FILL_DEF = 8'h20;

endpackage

// File: rtl/vram_host_fifo.sv
// Two-entry request queue between the host port and the RAM slot arbiter.
module vram_host_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    assign dout  = mem[rd_ptr];
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan, clear engine and queued host traffic.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int                DEPTH        = DEPTH_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter int                STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [DATA_W-1:0] FILL         = DATA_W'(FILL_DEF),
    localparam int               AW           = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_req,
    input  logic [AW-1:0]     scan_addr,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              host_starved,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int FW = 1 + AW + DATA_W;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic              head_we;
    logic [AW-1:0]     head_addr;
    logic [DATA_W-1:0] head_wdata;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     clr_cnt;
    logic              clr_last;
    logic [SW-1:0]     wait_cnt;
    tag_t              tag_q1;
    tag_t              tag_q2;
    owner_t            sel;
    logic              gnt_scan;
    logic              gnt_clr;
    logic              gnt_host;

    assign fifo_din = {host_we, host_addr, host_wdata};
    assign {head_we, head_addr, head_wdata} = fifo_dout;

    assign clear_busy = state_q == CLEAR;
    assign host_ready = !fifo_full && !clear_busy;
    assign fifo_push  = host_valid && host_ready;
    assign fifo_pop   = gnt_host;

    // Scan beats the clear engine, which beats the queued host head.
    assign gnt_scan = scan_req;
    assign gnt_clr  = !scan_req && clear_busy;
    assign gnt_host = !scan_req && !clear_busy && !fifo_empty;
    assign clr_last = clr_cnt == AW'(DEPTH - 1);

    assign scan_rvalid = tag_q2.valid && tag_q2.owner == SCAN;
    assign host_rvalid = tag_q2.valid && tag_q2.owner == HOST;
    assign scan_rdata  = ram_rdata;
    assign host_rdata  = ram_rdata;

    vram_host_fifo #(
        .W(FW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        sel = NONE;
        unique case (1'b1)
            gnt_scan: sel = SCAN;
            gnt_clr:  sel = CLR;
            gnt_host: sel = HOST;
            default:  sel = NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (clear_start) state_d = CLEAR;
            CLEAR:   if (gnt_clr && clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt      <= '0;
            wait_cnt     <= '0;
            host_starved <= 1'b0;
        end else begin
            if (gnt_clr) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end
            if (fifo_empty || gnt_host) begin
                wait_cnt <= '0;
            end else if (wait_cnt != SW'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Sticky: set on the cycle the wait reaches the limit.
            if (!fifo_empty && !gnt_host &&
                wait_cnt >= SW'(STARVE_LIMIT - 1)) begin
                host_starved <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tag_q1    <= '0;
            tag_q2    <= '0;
        end else begin
            ram_en <= sel != NONE;
            ram_we <= gnt_clr || (gnt_host && head_we);
            tag_q1 <= '{valid: gnt_scan || (gnt_host && !head_we),
                        owner: sel};
            tag_q2 <= tag_q1;
            unique case (sel)
                SCAN: ram_addr <= scan_addr;
                CLR: begin
                    ram_addr  <= clr_cnt;
                    ram_wdata <= FILL;
                end
                HOST: begin
                    ram_addr  <= head_addr;
                    ram_wdata <= head_wdata;
                end
                default: ram_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed table, corner sequences and randomized model check for vram_arbiter.
module tb_vram_arbiter;

    localparam int DEPTH = 16;
    localparam int LIM = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_req;
    logic [3:0] scan_addr;
    logic       scan_rvalid;
    logic [7:0] scan_rdata;
    logic       host_valid;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ready;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       clear_start;
    logic       clear_busy;
    logic       host_starved;
    logic       ram_en;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int sr, sa, hv, hw, ha, hd;
        int en, we, ad, wd, srv, hrv, rd;
    } vec_t;

    typedef struct {
        bit we;
        int addr;
        int data;
    } hreq_t;

    typedef struct {
        int due;
        int own;
        int data;
    } ret_t;

    hreq_t hq[$];
    ret_t  rq[$];
    int    shadow [DEPTH];
    bit    m_clear;
    int    clr_ptr;
    int    sc;
    bit    m_starved;
    int    ecnt;
    bit    x_en;
    bit    x_we;
    int    x_addr;
    int    x_wd;

    vram_arbiter #(
        .DEPTH(DEPTH),
        .DATA_W(8),
        .STARVE_LIMIT(LIM),
        .FILL(8'h20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_rvalid (scan_rvalid),
        .scan_rdata  (scan_rdata),
        .host_valid  (host_valid),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ready  (host_ready),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .host_starved(host_starved),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        scan_req    = 1'b0;
        scan_addr   = 4'd0;
        host_valid  = 1'b0;
        host_we     = 1'b0;
        host_addr   = 4'd0;
        host_wdata  = 8'd0;
        clear_start = 1'b0;
    endtask

    task automatic cmd(input string nm, input int en, input int we,
                       input int ad, input int wd);
        chk({nm, " ram_en"}, 32'(ram_en), 32'(en));
        chk({nm, " ram_we"}, 32'(ram_we), 32'(we));
        if (en != 0) chk({nm, " ram_addr"}, 32'(ram_addr), 32'(ad));
        if (we != 0) chk({nm, " ram_wdata"}, 32'(ram_wdata), 32'(wd));
    endtask

    // Transaction-level reference: priority pick, queue pop, delayed returns.
    task automatic model_edge();
        bit    had_head;
        bit    was_clear;
        bit    pre_ready;
        bit    host_gnt;
        hreq_t h;
        had_head  = hq.size() != 0;
        was_clear = m_clear;
        pre_ready = hq.size() < 2 && !m_clear;
        host_gnt  = 1'b0;
        ecnt++;
        x_en = 1'b0;
        x_we = 1'b0;
        if (scan_req) begin
            x_en   = 1'b1;
            x_addr = int'(scan_addr);
            rq.push_back('{ecnt + 1, 1, shadow[scan_addr]});
        end else if (m_clear) begin
            x_en   = 1'b1;
            x_we   = 1'b1;
            x_addr = clr_ptr;
            x_wd   = 'h20;
            shadow[clr_ptr] = 'h20;
            if (clr_ptr == DEPTH - 1) m_clear = 1'b0;
            else clr_ptr++;
        end else if (had_head) begin
            h        = hq.pop_front();
            host_gnt = 1'b1;
            x_en     = 1'b1;
            x_we     = h.we;
            x_addr   = h.addr;
            if (h.we) begin
                x_wd = h.data;
                shadow[h.addr] = h.data;
            end else begin
                rq.push_back('{ecnt + 1, 2, shadow[h.addr]});
            end
        end
        if (had_head && !host_gnt) begin
            sc++;
            if (sc >= LIM) m_starved = 1'b1;
        end else begin
            sc = 0;
        end
        if (host_valid && pre_ready)
            hq.push_back('{host_we, int'(host_addr), int'(host_wdata)});
        if (clear_start && !was_clear) begin
            m_clear = 1'b1;
            clr_ptr = 0;
        end
    endtask

    task automatic rstep();
        bit e_srv;
        bit e_hrv;
        int sd;
        int hd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e_srv = 1'b0;
        e_hrv = 1'b0;
        sd = 0;
        hd = 0;
        foreach (rq[i]) begin
            if (rq[i].due == ecnt && rq[i].own == 1) begin
                e_srv = 1'b1;
                sd = rq[i].data;
            end
            if (rq[i].due == ecnt && rq[i].own == 2) begin
                e_hrv = 1'b1;
                hd = rq[i].data;
            end
        end
        while (rq.size() != 0 && rq[0].due <= ecnt) void'(rq.pop_front());
        cmd("rnd", int'(x_en), int'(x_we), x_addr, x_wd);
        chk("rnd scan_rvalid", 32'(scan_rvalid), 32'(e_srv));
        chk("rnd host_rvalid", 32'(host_rvalid), 32'(e_hrv));
        if (e_srv) chk("rnd scan_rdata", 32'(scan_rdata), 32'(sd));
        if (e_hrv) chk("rnd host_rdata", 32'(host_rdata), 32'(hd));
        chk("rnd host_ready", 32'(host_ready),
            32'(hq.size() < 2 && !m_clear));
        chk("rnd clear_busy", 32'(clear_busy), 32'(m_clear));
        chk("rnd host_starved", 32'(host_starved), 32'(m_starved));
    endtask

    initial begin
        vec_t tbl[10];
        int   n;
        int   exp_a;
        int   bad;

        for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(8'h30 + i);
        mem[5] <= 8'h41;
        ram_rdata <= 8'h00;
        idle_in();
        rst_n = 1'b0;

        tbl[0] = '{1, 5, 0, 0, 0, 0,     1, 0, 5, 0,     0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     1, 0, 'h41};
        tbl[2] = '{0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0};
        tbl[3] = '{1, 2, 1, 1, 7, 'h5A,  1, 0, 2, 0,     0, 0, 0};
        tbl[4] = '{1, 3, 0, 0, 0, 0,     1, 0, 3, 0,     1, 0, 'h32};
        tbl[5] = '{0, 0, 0, 0, 0, 0,     1, 1, 7, 'h5A,  1, 0, 'h33};
        tbl[6] = '{0, 0, 1, 0, 7, 0,     0, 0, 0, 0,     0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0,     1, 0, 7, 0,     0, 0, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 1, 'h5A};
        tbl[9] = '{0, 0, 0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0};

        step();
        step();
        cmd("reset", 0, 0, 0, 0);
        chk("reset ram_addr", 32'(ram_addr), 0);
        chk("reset ram_wdata", 32'(ram_wdata), 0);
        chk("reset scan_rvalid", 32'(scan_rvalid), 0);
        chk("reset host_rvalid", 32'(host_rvalid), 0);
        chk("reset clear_busy", 32'(clear_busy), 0);
        chk("reset host_starved", 32'(host_starved), 0);
        rst_n = 1'b1;
        step();
        chk("post-reset host_ready", 32'(host_ready), 1);

        for (int i = 0; i < 10; i++) begin
            scan_req   = tbl[i].sr[0];
            scan_addr  = 4'(tbl[i].sa);
            host_valid = tbl[i].hv[0];
            host_we    = tbl[i].hw[0];
            host_addr  = 4'(tbl[i].ha);
            host_wdata = 8'(tbl[i].hd);
            step();
            cmd($sformatf("tbl%0d", i), tbl[i].en, tbl[i].we,
                tbl[i].ad, tbl[i].wd);
            chk($sformatf("tbl%0d scan_rvalid", i), 32'(scan_rvalid),
                32'(tbl[i].srv));
            chk($sformatf("tbl%0d host_rvalid", i), 32'(host_rvalid),
                32'(tbl[i].hrv));
            if (tbl[i].srv != 0)
                chk($sformatf("tbl%0d scan_rdata", i), 32'(scan_rdata),
                    32'(tbl[i].rd));
            if (tbl[i].hrv != 0)
                chk($sformatf("tbl%0d host_rdata", i), 32'(host_rdata),
                    32'(tbl[i].rd));
            chk($sformatf("tbl%0d host_ready", i), 32'(host_ready), 1);
        end
        idle_in();

        // FIFO fills while scan owns every slot; order kept after release.
        scan_req   = 1'b1;
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd1;
        host_wdata = 8'h11;
        step();
        chk("fill1 host_ready", 32'(host_ready), 1);
        host_addr  = 4'd2;
        host_wdata = 8'h22;
        step();
        chk("fill2 host_ready", 32'(host_ready), 0);
        host_addr  = 4'd3;
        host_wdata = 8'h33;
        step();
        chk("fill3 host_ready", 32'(host_ready), 0);
        step();
        chk("fill4 host_ready", 32'(host_ready), 0);
        scan_req = 1'b0;
        step();
        cmd("order1", 1, 1, 1, 'h11);
        chk("order1 host_ready", 32'(host_ready), 1);
        step();
        cmd("order2", 1, 1, 2, 'h22);
        host_valid = 1'b0;
        step();
        cmd("order3", 1, 1, 3, 'h33);
        step();
        cmd("order idle", 0, 0, 0, 0);

        // Clear with a queued host write and an ignored second pulse.
        clear_start = 1'b1;
        host_valid  = 1'b1;
        host_we     = 1'b1;
        host_addr   = 4'd9;
        host_wdata  = 8'h77;
        step();
        idle_in();
        chk("clear host_ready", 32'(host_ready), 0);
        n = 0;
        exp_a = 0;
        bad = 0;
        for (int i = 0; i < 40 && clear_busy; i++) begin
            n++;
            if (i == 3) clear_start = 1'b1;
            step();
            clear_start = 1'b0;
            if (ram_en) begin
                if (!(ram_we && ram_wdata == 8'h20 &&
                      int'(ram_addr) == exp_a)) bad++;
                exp_a++;
            end
        end
        chk("clear busy cycles", 32'(n), 16);
        chk("clear write count", 32'(exp_a), 16);
        chk("clear write content", 32'(bad), 0);
        step();
        chk("clear no restart", 32'(clear_busy), 0);
        cmd("clear retained", 1, 1, 9, 'h77);
        step();
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ((i == 9) ? 8'h77 : 8'h20)) bad++;
        chk("clear cells", 32'(bad), 0);

        // Starvation: one queued read behind a continuous scan.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        scan_req   = 1'b1;
        scan_addr  = 4'd1;
        host_valid = 1'b1;
        host_addr  = 4'd4;
        step();
        host_valid = 1'b0;
        repeat (63) step();
        chk("starve early", 32'(host_starved), 0);
        step();
        chk("starve set", 32'(host_starved), 1);
        scan_req = 1'b0;
        step();
        cmd("starve grant", 1, 0, 4, 0);
        step();
        step();
        chk("starve sticky", 32'(host_starved), 1);

        // Reset during a clear with a scan read in flight.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        step();
        scan_req  = 1'b1;
        scan_addr = 4'd2;
        step();
        chk("abort busy before", 32'(clear_busy), 1);
        scan_req = 1'b0;
        rst_n = 1'b0;
        step();
        chk("abort clear_busy", 32'(clear_busy), 0);
        chk("abort scan_rvalid", 32'(scan_rvalid), 0);
        chk("abort host_rvalid", 32'(host_rvalid), 0);
        cmd("abort", 0, 0, 0, 0);
        chk("abort ram_addr", 32'(ram_addr), 0);
        chk("abort host_ready", 32'(host_ready), 1);
        rst_n = 1'b1;
        step();
        chk("abort late scan_rvalid", 32'(scan_rvalid), 0);
        chk("abort late clear_busy", 32'(clear_busy), 0);

        for (int i = 0; i < DEPTH; i++) shadow[i] = int'(mem[i]);
        hq.delete();
        rq.delete();
        m_clear   = 1'b0;
        clr_ptr   = 0;
        sc        = 0;
        m_starved = 1'b0;
        ecnt      = 0;
        for (int c = 0; c < 1000; c++) begin
            scan_req    = $urandom_range(0, 9) < 6;
            scan_addr   = 4'($urandom_range(0, DEPTH - 1));
            host_valid  = $urandom_range(0, 2) != 0;
            host_we     = 1'($urandom_range(0, 1));
            host_addr   = 4'($urandom_range(0, DEPTH - 1));
            host_wdata  = 8'($urandom);
            clear_start = $urandom_range(0, 63) == 0;
            rstep();
        end
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
